// File: rtl/dmg_mem_pkg.sv
// Shared types and defaults for the OAM DMA / CPU memory arbiter.
package dmg_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    GAP,
    DONE
  } dma_state_e;

  localparam logic [15:0] OAM_BASE_DEFAULT = 16'hFE00;
  localparam int          DMA_LEN_DEFAULT  = 160;

endpackage

// File: rtl/oam_dma_seq.sv
// OAM DMA sequencer: page latch, byte index and RD/WR address/enable generation.
// Latency: first RD one cycle after dma_start is sampled, one byte per RD+WR pair.
// Backpressure: none; optional GAP slot (ARB_CPU_SLOT_EN, via gap_req) lets the CPU in between bytes.
module oam_dma_seq
  import dmg_mem_pkg::*;
#(
  parameter int                     p_ADDR_BITS = 16,
  parameter int                     p_DMA_LEN   = DMA_LEN_DEFAULT,
  parameter logic [p_ADDR_BITS-1:0] p_OAM_BASE  = p_ADDR_BITS'(OAM_BASE_DEFAULT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   dma_start,
  input  logic [7:0]             dma_src_page,
  input  logic                   gap_req,
  output dma_state_e             dma_state,
  output logic                   dma_ren,
  output logic                   dma_wen,
  output logic [p_ADDR_BITS-1:0] dma_addr,
  output logic                   dma_busy,
  output logic                   dma_done
);

  dma_state_e state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] page_q, page_d;
  logic       last_byte;

  assign last_byte = (idx_q == 8'(p_DMA_LEN - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 8'h00;
      page_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      page_q  <= page_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    page_d   = page_q;
    dma_ren  = 1'b0;
    dma_wen  = 1'b0;
    // Source index is 8 bits so the read address stays inside the latched page.
    dma_addr = p_ADDR_BITS'({page_q, idx_q});
    case (state_q)
      IDLE: begin
        if (dma_start) begin
          state_d = RD;
          page_d  = dma_src_page;
          idx_d   = 8'h00;
        end
      end
      RD: begin
        dma_ren = 1'b1;
        state_d = WR;
      end
      WR: begin
        dma_wen  = 1'b1;
        dma_addr = p_OAM_BASE + p_ADDR_BITS'(idx_q);
        idx_d    = idx_q + 8'd1;
        if (last_byte)    state_d = DONE;
        else if (gap_req) state_d = GAP;
        else              state_d = RD;
      end
      GAP:     state_d = RD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign dma_state = state_q;
  assign dma_busy  = (state_q == RD) || (state_q == WR) || (state_q == GAP);
  assign dma_done  = (state_q == DONE);

endmodule

// File: rtl/oam_dma_arbiter.sv
// Arbitrates one single-port sync RAM between the CPU bus and the OAM DMA engine.
// Latency: CPU grant is combinational, read data valid one cycle after a granted read.
// Backpressure: CPU held off (cpu_gnt=0) while DMA owns the port; ARB_CPU_SLOT_EN adds per-byte CPU slots.
module oam_dma_arbiter
  import dmg_mem_pkg::*;
#(
  parameter int                     p_ADDR_BITS = 16,
  parameter int                     p_DATA_BITS = 8,
  parameter int                     p_DMA_LEN   = DMA_LEN_DEFAULT,
  parameter logic [p_ADDR_BITS-1:0] p_OAM_BASE  = p_ADDR_BITS'(OAM_BASE_DEFAULT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cpu_req,
  input  logic                   cpu_wen,
  input  logic [p_ADDR_BITS-1:0] cpu_addr,
  input  logic [p_DATA_BITS-1:0] cpu_wdata,
  output logic                   cpu_gnt,
  output logic                   cpu_rvalid,
  output logic [p_DATA_BITS-1:0] cpu_rdata,
  input  logic                   dma_start,
  input  logic [7:0]             dma_src_page,
  output logic                   dma_busy,
  output logic                   dma_done,
  output logic [p_ADDR_BITS-1:0] mem_addr,
  output logic                   mem_ren,
  output logic                   mem_wen,
  output logic [p_DATA_BITS-1:0] mem_data,
  input  logic [p_DATA_BITS-1:0] mem_q
);

  dma_state_e             dma_state;
  logic                   dma_ren;
  logic                   dma_wen;
  logic [p_ADDR_BITS-1:0] dma_addr;
  logic                   gap_req;
  logic                   slot_open;
  logic                   cpu_rvalid_q, cpu_rvalid_d;

`ifdef ARB_CPU_SLOT_EN
  assign gap_req   = cpu_req;
  assign slot_open = (dma_state == GAP);
`else
  assign gap_req   = 1'b0;
  assign slot_open = 1'b0;
`endif

  oam_dma_seq #(
    .p_ADDR_BITS (p_ADDR_BITS),
    .p_DMA_LEN   (p_DMA_LEN),
    .p_OAM_BASE  (p_OAM_BASE)
  ) u_seq (
    .clk          (clk),
    .rst_n        (rst_n),
    .dma_start    (dma_start),
    .dma_src_page (dma_src_page),
    .gap_req      (gap_req),
    .dma_state    (dma_state),
    .dma_ren      (dma_ren),
    .dma_wen      (dma_wen),
    .dma_addr     (dma_addr),
    .dma_busy     (dma_busy),
    .dma_done     (dma_done)
  );

  // RD and WR are back to back, so the CPU can never land between them and overwrite q.
  always_comb begin
    cpu_gnt = rst_n & cpu_req &
              ((dma_state == IDLE) | (dma_state == DONE) | slot_open);
    mem_addr = dma_addr;
    mem_ren  = rst_n & dma_ren;
    mem_wen  = rst_n & dma_wen;
    mem_data = mem_q;
    if (cpu_gnt) begin
      mem_addr = cpu_addr;
      mem_ren  = ~cpu_wen;
      mem_wen  = cpu_wen;
      mem_data = cpu_wdata;
    end
    cpu_rvalid_d = cpu_gnt & ~cpu_wen;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cpu_rvalid_q <= 1'b0;
    else        cpu_rvalid_q <= cpu_rvalid_d;
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_rdata  = mem_q;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Scoreboard bench for oam_dma_arbiter: default-length instance plus a 256-byte instance for page wrap.
module tb_oam_dma_arbiter;

`ifdef ARB_CPU_SLOT_EN
  localparam int N_ACC     = 3;
  localparam int HOLD_WAIT = 2;
  localparam int HOLD_DONE = 321 + N_ACC;
`else
  localparam int N_ACC     = 1;
  localparam int HOLD_WAIT = 320;
  localparam int HOLD_DONE = 321;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic        a_cpu_req, a_cpu_wen, a_cpu_gnt, a_cpu_rvalid;
  logic [15:0] a_cpu_addr, a_mem_addr;
  logic [7:0]  a_cpu_wdata, a_cpu_rdata, a_dma_src_page, a_mem_data, a_mem_q;
  logic        a_dma_start, a_dma_busy, a_dma_done, a_mem_ren, a_mem_wen;

  logic        b_cpu_req, b_cpu_wen, b_cpu_gnt, b_cpu_rvalid;
  logic [15:0] b_cpu_addr, b_mem_addr;
  logic [7:0]  b_cpu_wdata, b_cpu_rdata, b_dma_src_page, b_mem_data, b_mem_q;
  logic        b_dma_start, b_dma_busy, b_dma_done, b_mem_ren, b_mem_wen;

  oam_dma_arbiter u_dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(a_cpu_req), .cpu_wen(a_cpu_wen), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
    .cpu_gnt(a_cpu_gnt), .cpu_rvalid(a_cpu_rvalid), .cpu_rdata(a_cpu_rdata),
    .dma_start(a_dma_start), .dma_src_page(a_dma_src_page), .dma_busy(a_dma_busy), .dma_done(a_dma_done),
    .mem_addr(a_mem_addr), .mem_ren(a_mem_ren), .mem_wen(a_mem_wen), .mem_data(a_mem_data), .mem_q(a_mem_q)
  );

  oam_dma_arbiter #(.p_DMA_LEN(256)) u_dut256 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(b_cpu_req), .cpu_wen(b_cpu_wen), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_gnt(b_cpu_gnt), .cpu_rvalid(b_cpu_rvalid), .cpu_rdata(b_cpu_rdata),
    .dma_start(b_dma_start), .dma_src_page(b_dma_src_page), .dma_busy(b_dma_busy), .dma_done(b_dma_done),
    .mem_addr(b_mem_addr), .mem_ren(b_mem_ren), .mem_wen(b_mem_wen), .mem_data(b_mem_data), .mem_q(b_mem_q)
  );

  logic [7:0] mem_a [0:65535];
  logic [7:0] mem_b [0:65535];

  always @(posedge clk) begin
    if (a_mem_wen) mem_a[a_mem_addr] = a_mem_data;
    if (a_mem_ren) a_mem_q <= mem_a[a_mem_addr];
    if (b_mem_wen) mem_b[b_mem_addr] = b_mem_data;
    if (b_mem_ren) b_mem_q <= mem_b[b_mem_addr];
  end

  logic [7:0]  rd_d_q [$];
  int          rd_c_q [$];
  logic [23:0] wa_q [$];
  logic [23:0] wb_q [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail_event(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=no_event", nm);
  endtask

  always @(negedge clk) begin
    if (a_cpu_rvalid) begin
      if (rd_d_q.size() == 0) fail_event("rvalid_unexpected");
      else begin
        check("rvalid_cycle", cyc, rd_c_q.pop_front());
        check("cpu_rdata", a_cpu_rdata, rd_d_q.pop_front());
      end
    end
    if (a_mem_wen && !a_cpu_gnt) begin
      if (wa_q.size() == 0) fail_event("dma_write_unexpected");
      else check("dma_write", {a_mem_addr, a_mem_data}, wa_q.pop_front());
    end
    if (b_mem_wen) begin
      if (wb_q.size() == 0) fail_event("dma256_write_unexpected");
      else check("dma256_write", {b_mem_addr, b_mem_data}, wb_q.pop_front());
    end
    if (a_dma_done) done_cnt++;
  end

  task automatic preload(input bit is_b, input logic [7:0] page, input logic [7:0] xorv);
    for (int i = 0; i < 256; i++) begin
      if (is_b) mem_b[{page, 8'(i)}] = 8'(i) ^ xorv;
      else      mem_a[{page, 8'(i)}] = 8'(i) ^ xorv;
    end
  endtask

  task automatic push_copy(input bit is_b, input logic [7:0] xorv, input int n);
    for (int i = 0; i < n; i++) begin
      if (is_b) wb_q.push_back({16'(16'hFE00 + i), 8'(i) ^ xorv});
      else      wa_q.push_back({16'(16'hFE00 + i), 8'(i) ^ xorv});
    end
  endtask

  task automatic start_dma(input logic [7:0] page);
    a_dma_start    = 1'b1;
    a_dma_src_page = page;
    @(posedge clk); #1;
    a_dma_start = 1'b0;
  endtask

  task automatic cpu_access(input logic wen, input logic [15:0] addr, input logic [7:0] wd,
                            input logic [7:0] exp_rd, input int exp_wait, input string nm);
    int waited = 0;
    bit got = 0;
    a_cpu_req = 1'b1; a_cpu_wen = wen; a_cpu_addr = addr; a_cpu_wdata = wd;
    while (!got && waited <= 600) begin
      @(negedge clk);
      if (a_cpu_gnt) begin
        got = 1;
        check($sformatf("%s_mem_addr", nm), a_mem_addr, addr);
        check($sformatf("%s_mem_ren", nm), a_mem_ren, !wen);
        check($sformatf("%s_mem_wen", nm), a_mem_wen, wen);
        if (wen) check($sformatf("%s_mem_data", nm), a_mem_data, wd);
        else begin
          rd_d_q.push_back(exp_rd);
          rd_c_q.push_back(cyc + 1);
        end
      end else waited++;
      @(posedge clk); #1;
    end
    a_cpu_req = 1'b0;
    if (!got) fail_event($sformatf("%s_gnt_timeout", nm));
    else check($sformatf("%s_gnt_wait", nm), waited, exp_wait);
  endtask

  // Called at posedge+1 of cycle 1, i.e. start was sampled at the end of cycle 0.
  task automatic dma_wait(input logic [7:0] page, input int exp_done, input string nm);
    int busy_cnt = 0;
    bit seen = 0;
    for (int n = 1; n <= exp_done + 50 && !seen; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check($sformatf("%s_first_ren", nm), a_mem_ren, 1'b1);
        check($sformatf("%s_first_addr", nm), a_mem_addr, {page, 8'h00});
      end
      if (a_dma_busy) busy_cnt++;
      if (a_dma_done) begin
        seen = 1;
        check($sformatf("%s_done_cycle", nm), n, exp_done);
      end
      @(posedge clk); #1;
    end
    if (!seen) fail_event($sformatf("%s_done_timeout", nm));
    check($sformatf("%s_busy_cycles", nm), busy_cnt, exp_done - 1);
    check($sformatf("%s_writes_left", nm), wa_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bit seen;
    rst_n = 1'b0;
    a_cpu_req = 1'b1; a_cpu_wen = 1'b0; a_cpu_addr = 16'h0000; a_cpu_wdata = 8'h00;
    a_dma_start = 1'b0; a_dma_src_page = 8'h00;
    b_cpu_req = 1'b0; b_cpu_wen = 1'b0; b_cpu_addr = 16'h0000; b_cpu_wdata = 8'h00;
    b_dma_start = 1'b0; b_dma_src_page = 8'h00;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_gnt", a_cpu_gnt, 1'b0);
    check("rst_mem_ren", a_mem_ren, 1'b0);
    check("rst_mem_wen", a_mem_wen, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    a_cpu_req = 1'b0;
    @(negedge clk);
    check("rst_dma_busy", a_dma_busy, 1'b0);
    check("rst_dma_done", a_dma_done, 1'b0);
    check("rst_cpu_rvalid", a_cpu_rvalid, 1'b0);
    check("rst_dma256_busy", b_dma_busy, 1'b0);
    @(posedge clk); #1;

    cpu_access(1'b1, 16'hC000, 8'h5A, 8'h00, 0, "cpu_wr");
    cpu_access(1'b0, 16'hC000, 8'h00, 8'h5A, 0, "cpu_rd");

    preload(1'b0, 8'hC0, 8'h00);
    preload(1'b0, 8'hD0, 8'hFF);
    push_copy(1'b0, 8'h00, 160);
    start_dma(8'hC0);
    dma_wait(8'hC0, 321, "copy");
    cpu_access(1'b0, 16'hFE9F, 8'h00, 8'h9F, 0, "oam_rd");

    push_copy(1'b0, 8'h00, 160);
    start_dma(8'hC0);
    fork
      dma_wait(8'hC0, HOLD_DONE, "hold");
      begin
        for (int k = 0; k < N_ACC; k++)
          cpu_access(1'b0, 16'(16'hC005 + k), 8'h00, 8'(5 + k), HOLD_WAIT, "cpu_hold");
      end
    join

    push_copy(1'b0, 8'h00, 160);
    start_dma(8'hC0);
    fork
      dma_wait(8'hC0, 321, "restart_ignored");
      begin
        repeat (9) @(posedge clk);
        #1;
        a_dma_start = 1'b1; a_dma_src_page = 8'hD0;
        @(posedge clk); #1;
        a_dma_start = 1'b0; a_dma_src_page = 8'hC0;
      end
    join

    push_copy(1'b0, 8'h00, 160);
    a_cpu_req = 1'b1; a_cpu_wen = 1'b0; a_cpu_addr = 16'hC010;
    a_dma_start = 1'b1; a_dma_src_page = 8'hC0;
    @(negedge clk);
    check("same_cycle_gnt", a_cpu_gnt, 1'b1);
    check("same_cycle_addr", a_mem_addr, 16'hC010);
    check("same_cycle_ren", a_mem_ren, 1'b1);
    rd_d_q.push_back(8'h10);
    rd_c_q.push_back(cyc + 1);
    @(posedge clk); #1;
    a_cpu_req = 1'b0; a_dma_start = 1'b0;
    dma_wait(8'hC0, 321, "same_cycle");

    push_copy(1'b0, 8'h00, 50);
    d0 = done_cnt;
    start_dma(8'hC0);
    repeat (101) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_mem_wen", a_mem_wen, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_busy", a_dma_busy, 1'b0);
    check("abort_no_done", done_cnt, d0);
    check("abort_writes_left", wa_q.size(), 0);
    @(posedge clk); #1;

    preload(1'b1, 8'hFF, 8'hA5);
    push_copy(1'b1, 8'hA5, 256);
    b_dma_start = 1'b1; b_dma_src_page = 8'hFF;
    @(posedge clk); #1;
    b_dma_start = 1'b0;
    seen = 0;
    for (int n = 1; n <= 600 && !seen; n++) begin
      @(negedge clk);
      if (n == 1) check("wrap_first_addr", b_mem_addr, 16'hFF00);
      if (b_dma_done) begin
        seen = 1;
        check("wrap_done_cycle", n, 513);
      end
      @(posedge clk); #1;
    end
    if (!seen) fail_event("wrap_done_timeout");
    check("wrap_writes_left", wb_q.size(), 0);
    check("reads_left", rd_d_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
